// File: rtl/input_conditioner_pkg.sv
// Shared types and helpers for the input conditioner.
// Output-mode encoding and debounce counter sizing.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'd0,
    MODE_RISE   = 2'd1,
    MODE_FALL   = 2'd2,
    MODE_TOGGLE = 2'd3
  } cond_mode_t;

  function automatic int dbnc_w(int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Channel bundle between the pin side and the conditioner.
// master drives raw inputs/controls, slave returns conditioned outputs.
interface input_conditioner_if #(
  parameter int N_CH = 8
);
  logic [N_CH-1:0]   din;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   toggle_clr;
  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   fall;
  logic [N_CH-1:0]   cond_out;
  logic              changed;

  modport master (
    output din, mode, toggle_clr,
    input  level, rise, fall, cond_out, changed
  );

  modport slave (
    input  din, mode, toggle_clr,
    output level, rise, fall, cond_out, changed
  );
endinterface

// File: rtl/input_conditioner_channel.sv
// One conditioned channel: sync, polarity fix, debounce,
// edge pulses and a toggle latch.
module cond_channel
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic INV             = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  input  logic tgl_clr_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic tgl_o
);

  localparam int CW  = dbnc_w(DEBOUNCE_CYCLES);
  localparam int LIM =
    ((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1) - 1;
  localparam logic [CW-1:0] CMAX = CW'(LIM);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   level_q, rise_q, fall_q, tgl_q;
  logic                   rise_d, fall_d, tgl_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1] ^ INV;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CMAX) begin
      stable_d = s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pulses are aligned with the cycle level first shows the new value.
  always_comb begin
    rise_d = stable_q & ~level_q;
    fall_d = ~stable_q & level_q;
    tgl_d  = tgl_q;
    if (tgl_clr_i) tgl_d = 1'b0;
    else if (rise_d) tgl_d = ~tgl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{INV}};
      cnt_q    <= '0;
      stable_q <= 1'b0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      tgl_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      level_q  <= stable_q;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      tgl_q    <= tgl_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign tgl_o   = tgl_q;

endmodule

// File: rtl/input_conditioner.sv
// N_CH independent conditioned inputs with a per-channel
// output mode select and a global change flag.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int              N_CH            = 8,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter logic [N_CH-1:0] INV_MASK        = '0
) (
  input logic                 clk,
  input logic                 reset,
  input_conditioner_if.slave  bus
);

  logic [N_CH-1:0] level, rise, fall, tgl, cond;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cond_mode_t m;

    cond_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INV             (INV_MASK[i])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .din_i     (bus.din[i]),
      .tgl_clr_i (bus.toggle_clr[i]),
      .level_o   (level[i]),
      .rise_o    (rise[i]),
      .fall_o    (fall[i]),
      .tgl_o     (tgl[i])
    );

    assign m = cond_mode_t'(bus.mode[2*i +: 2]);

    always_comb begin
      cond[i] = 1'b0;
      unique case (m)
        MODE_LEVEL:  cond[i] = level[i];
        MODE_RISE:   cond[i] = rise[i];
        MODE_FALL:   cond[i] = fall[i];
        MODE_TOGGLE: cond[i] = tgl[i];
        default:     cond[i] = 1'b0;
      endcase
    end
  end

  assign bus.level    = level;
  assign bus.rise     = rise;
  assign bus.fall     = fall;
  assign bus.cond_out = cond;
  assign bus.changed  = |{rise, fall};

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: N_CH=4, D=4,
// INV_MASK=0001, hand-computed expectations.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  input_conditioner_if #(.N_CH(4)) bus ();

  input_conditioner #(
    .N_CH            (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .INV_MASK        (4'b0001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.din        = 4'b0001;
    bus.mode       = 8'h00;
    bus.toggle_clr = 4'b0000;

    // 1: reset with ch0 idle-high
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_level", 32'(bus.level), 0);
      chk("rst_edges", 32'({bus.rise, bus.fall}), 0);
      chk("rst_cond", 32'({bus.cond_out, bus.changed}), 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rel_level", 32'(bus.level), 0);
      chk("rel_edges", 32'({bus.rise, bus.fall}), 0);
      chk("rel_cond", 32'({bus.cond_out, bus.changed}), 0);
    end

    // 2: clean step on ch1, mode RISE
    bus.mode = 8'h04;
    bus.din  = 4'b0011;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("step_level1", 32'(bus.level[1]), 32'(i >= 7));
      chk("step_rise1", 32'(bus.rise[1]), 32'(i == 7));
      chk("step_cond1", 32'(bus.cond_out[1]), 32'(i == 7));
      chk("step_changed", 32'(bus.changed), 32'(i == 7));
    end

    // 3: 3-cycle glitch on ch2, then a real step
    bus.din = 4'b0111;
    step(3);
    bus.din = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("glitch_level2", 32'(bus.level[2]), 0);
      chk("glitch_edges", 32'({bus.rise, bus.fall}), 0);
      chk("glitch_changed", 32'(bus.changed), 0);
    end
    bus.din = 4'b0111;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("glitch2_level2", 32'(bus.level[2]), 32'(i == 7));
    end

    // 4: toggle presses on ch3
    bus.mode = 8'hC4;
    bus.din  = 4'b1111;
    step(10);
    chk("tgl_press1", 32'(bus.cond_out[3]), 1);
    bus.din = 4'b0111;
    step(10);
    chk("tgl_rel1", 32'(bus.cond_out[3]), 1);
    bus.din = 4'b1111;
    step(10);
    chk("tgl_press2", 32'(bus.cond_out[3]), 0);
    bus.din = 4'b0111;
    step(10);
    bus.din = 4'b1111;
    step(10);
    chk("tgl_press3", 32'(bus.cond_out[3]), 1);
    bus.din = 4'b0111;
    step(10);
    bus.din        = 4'b1111;
    bus.toggle_clr = 4'b1000;
    step(10);
    chk("tgl_clr_cond", 32'(bus.cond_out[3]), 0);
    chk("tgl_clr_level", 32'(bus.level[3]), 1);
    bus.toggle_clr = 4'b0000;
    bus.din        = 4'b0111;
    step(10);

    // 5: reset in the middle of a debounce count
    bus.din = 4'b0001;
    reset   = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);
    chk("mid_pre_level", 32'(bus.level), 0);
    bus.din = 4'b0011;
    step(4);
    reset = 1'b1;
    step();
    chk("mid_rst_level1", 32'(bus.level[1]), 0);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("mid_level1", 32'(bus.level[1]), 32'(i == 7));
    end

    // 6: simultaneous falls on all channels
    bus.mode = 8'hAA;
    bus.din  = 4'b1110;
    step(10);
    chk("sim_all_high", 32'(bus.level), 32'hF);
    bus.din = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("sim_fall", 32'(bus.fall), (i == 7) ? 32'hF : 0);
      chk("sim_cond", 32'(bus.cond_out), (i == 7) ? 32'hF : 0);
      chk("sim_changed", 32'(bus.changed), 32'(i == 7));
      chk("sim_rise", 32'(bus.rise), 0);
    end
    chk("sim_level_low", 32'(bus.level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
